// File: rtl/ram_param_pkg.sv
// Shared constants and FSM state type for the ram_param block.
package ram_param_pkg;
  localparam int WIDTH_DEF = 16;
  localparam int AW_DEF    = 9;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;
endpackage

// File: rtl/ram_param_if.sv
// User-side bus of ram_param: write/read request, clear request, read data and busy.
interface ram_param_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 9
);
  logic [WIDTH-1:0] in;
  logic             load;
  logic [AW-1:0]    address;
  logic             clear;
  logic [WIDTH-1:0] out;
  logic             busy;

  modport master (
    output in, load, address, clear,
    input  out, busy
  );

  modport slave (
    input  in, load, address, clear,
    output out, busy
  );
endinterface

// File: rtl/ram_clear_ctrl.sv
// Clear-sweep controller: walks every address once, writing zero, after reset or a clear request.
module ram_clear_ctrl
  import ram_param_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  output logic          busy_o,
  output logic [AW-1:0] sweep_addr_o,
  output logic          sweep_we_o
);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;

  // Next-state and sweep counter; the final address returns to IDLE instead of wrapping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clear_i) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        if (cnt_q == {AW{1'b1}}) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + {{(AW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == CLEAR);
  end

  // State, counter and busy registers; reset starts a fresh sweep from address 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign busy_o       = busy_q;
  assign sweep_addr_o = cnt_q;
  assign sweep_we_o   = (state_q == CLEAR);

endmodule

// File: rtl/ram_param.sv
// Single-port RAM with registered read and self-clearing sweep.
// Define RAM_PARAM_BYPASS_EN for write-first read-during-write; default is read-first.
module ram_param
  import ram_param_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AW    = AW_DEF
) (
  input logic       clk,
  input logic       rst_n,
  ram_param_if.slave bus
);

  localparam int DEPTH = 2 ** AW;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] out_q, out_d;

  logic             busy_s;
  logic [AW-1:0]    sweep_addr_s;
  logic             sweep_we_s;
  logic             wr_en_s;
  logic [AW-1:0]    wr_addr_s;
  logic [WIDTH-1:0] wr_data_s;
  logic [WIDTH-1:0] rd_data_s;

  ram_clear_ctrl #(.AW(AW)) u_clear_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (bus.clear),
    .busy_o       (busy_s),
    .sweep_addr_o (sweep_addr_s),
    .sweep_we_o   (sweep_we_s)
  );

  // Write-port mux: the sweep owns the port while it runs, user requests are dropped.
  always_comb begin
    if (sweep_we_s) begin
      wr_en_s   = 1'b1;
      wr_addr_s = sweep_addr_s;
      wr_data_s = '0;
    end else begin
      wr_en_s   = bus.load;
      wr_addr_s = bus.address;
      wr_data_s = bus.in;
    end
  end

  // Storage array; contents are zeroed by the sweep rather than by reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_addr_s] <= wr_data_s;
    end
  end

  assign rd_data_s = mem_q[bus.address];

  // Read data; forced to zero while sweeping, including the cycle a clear is accepted.
  always_comb begin
    if (busy_s || bus.clear) begin
      out_d = '0;
    end else begin
`ifdef RAM_PARAM_BYPASS_EN
      if (bus.load) begin
        out_d = bus.in;
      end else begin
        out_d = rd_data_s;
      end
`else
      out_d = rd_data_s;
`endif
    end
  end

  // Output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.busy = busy_s;

endmodule
